// File: rtl/vga_pkg.sv
// Shared definitions for the lane game: 12-bit RGB colours, palette codes,
// the per-lane FSM state type and the palette lookup.
package vga_pkg;

  localparam logic [11:0] COL_BLACK     = 12'h000;
  localparam logic [11:0] COL_BG        = 12'h124;
  localparam logic [11:0] COL_O         = 12'hF80;
  localparam logic [11:0] COL_P2        = 12'hF0F;
  localparam logic [11:0] COL_P3        = 12'hA0F;
  localparam logic [11:0] COL_B1        = 12'h00F;
  localparam logic [11:0] COL_B2        = 12'h08F;
  localparam logic [11:0] COL_B3        = 12'h0FF;
  localparam logic [11:0] COL_TEXT      = 12'hFFF;
  localparam logic [11:0] COL_HIGHLIGHT = 12'hFF0;
  localparam logic [11:0] COL_GREY      = 12'h888;
  localparam logic [11:0] COL_GREEN     = 12'h0F0;

  typedef enum logic [3:0] {
    PAL_BG        = 4'd1,
    PAL_O         = 4'd2,
    PAL_P2        = 4'd3,
    PAL_P3        = 4'd4,
    PAL_B1        = 4'd5,
    PAL_B2        = 4'd6,
    PAL_B3        = 4'd7,
    PAL_TEXT      = 4'd8,
    PAL_HIGHLIGHT = 4'd9,
    PAL_GREY      = 4'd10
  } pal_code_e;

  typedef enum logic {
    LANE_ARMED  = 1'b0,
    LANE_SCORED = 1'b1
  } lane_state_e;

  // Codes without a palette entry (0, 11..15) fall back to the background.
  function automatic logic [11:0] pal_colour(input logic [3:0] code);
    logic [11:0] col;
    case (code)
      PAL_BG:        col = COL_BG;
      PAL_O:         col = COL_O;
      PAL_P2:        col = COL_P2;
      PAL_P3:        col = COL_P3;
      PAL_B1:        col = COL_B1;
      PAL_B2:        col = COL_B2;
      PAL_B3:        col = COL_B3;
      PAL_TEXT:      col = COL_TEXT;
      PAL_HIGHLIGHT: col = COL_HIGHLIGHT;
      PAL_GREY:      col = COL_GREY;
      default:       col = COL_BG;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/vga_lane_ctrl.sv
// One falling-block lane: vertical position, ARMED/SCORED FSM, button edge
// detect and registered hit/miss strobes.
module vga_lane_ctrl
  import vga_pkg::*;
#(
  parameter int         VMAX    = 779,
  parameter int         HIT_LO  = 400,
  parameter int         HIT_HI  = 475,
  parameter int         REARM_Y = 20,
  parameter logic [9:0] INIT_Y  = 10'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        button,
  output logic [9:0]  lane_y,
  output lane_state_e state,
  output logic        hit_evt,
  output logic        hit_pulse,
  output logic        miss_pulse
);

  logic [9:0]  y_q, y_d;
  lane_state_e state_q, state_d;
  logic        btn_prev_q;
  logic        hit_pulse_q, miss_pulse_q;
  logic        rise, in_win, miss_evt;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    rise     = button & ~btn_prev_q;
    in_win   = (y_q >= 10'(HIT_LO)) && (y_q <= 10'(HIT_HI));
    // Both events judge the state held at the start of the cycle, so a
    // press that coincides with a re-arm still counts as a SCORED press.
    hit_evt  = rise && (state_q == LANE_ARMED) && in_win;
    miss_evt = rise && !hit_evt;

    y_d = y_q;
    if (tick) begin
      y_d = (y_q == 10'(VMAX)) ? 10'd0 : y_q + 10'd1;
    end

    state_d = state_q;
    case (state_q)
      LANE_ARMED:  if (hit_evt) state_d = LANE_SCORED;
      LANE_SCORED: if (y_q <= 10'(REARM_Y)) state_d = LANE_ARMED;
      default:     state_d = LANE_ARMED;
    endcase
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk) begin
    if (reset) begin
      y_q          <= INIT_Y;
      state_q      <= LANE_ARMED;
      btn_prev_q   <= 1'b0;
      hit_pulse_q  <= 1'b0;
      miss_pulse_q <= 1'b0;
    end else begin
      y_q          <= y_d;
      state_q      <= state_d;
      btn_prev_q   <= button;
      hit_pulse_q  <= hit_evt;
      miss_pulse_q <= miss_evt;
    end
  end

  assign lane_y     = y_q;
  assign state      = state_q;
  assign hit_pulse  = hit_pulse_q;
  assign miss_pulse = miss_pulse_q;

endmodule

// File: rtl/vga_lane_game.sv
// Lane rhythm game overlay: shared descent tick, saturating score and the
// registered colour mux that paints lane blocks over the palette pixel.
module vga_lane_game
  import vga_pkg::*;
#(
  parameter int NLANES     = 4,
  parameter int CIDXW      = 4,
  parameter int SCOREW     = 16,
  parameter int TICK_DIV   = 500000,
  parameter int VMAX       = 779,
  parameter int HIT_LO     = 400,
  parameter int HIT_HI     = 475,
  parameter int REARM_Y    = 20,
  parameter int BLOCK_W    = 40,
  parameter int BLOCK_H    = 40,
  parameter int LANE_X0    = 200,
  parameter int LANE_PITCH = 80
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bright,
  input  logic [9:0]           hCount,
  input  logic [9:0]           vCount,
  input  logic [CIDXW-1:0]     pix,
  input  logic [NLANES-1:0]    button,
  output logic [11:0]          rgb,
  output logic [SCOREW-1:0]    score,
  output logic [10*NLANES-1:0] lane_y,
  output logic [NLANES-1:0]    hit_pulse,
  output logic [NLANES-1:0]    miss_pulse
);

  localparam int TCW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SUMW = SCOREW + $clog2(NLANES + 1) + 1;
  localparam logic [SCOREW-1:0] SCORE_MAX = '1;

  logic [TCW-1:0]    tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [SCOREW-1:0] score_q, score_d;
  logic [SUMW-1:0]   hit_cnt, score_sum;
  logic [11:0]       rgb_q, rgb_d;
  logic [11:0]       ov_col;
  logic              ov_hit;
  logic [CIDXW+3:0]  pix_ext;

  logic [9:0]        lane_y_arr [NLANES];
  lane_state_e       lane_st    [NLANES];
  logic [NLANES-1:0] hit_evt;

  assign tick = (tick_cnt_q == TCW'(TICK_DIV - 1));

  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    vga_lane_ctrl #(
      .VMAX    (VMAX),
      .HIT_LO  (HIT_LO),
      .HIT_HI  (HIT_HI),
      .REARM_Y (REARM_Y),
      .INIT_Y  (10'((i * (VMAX + 1)) / NLANES))
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
      .tick       (tick),
      .button     (button[i]),
      .lane_y     (lane_y_arr[i]),
      .state      (lane_st[i]),
      .hit_evt    (hit_evt[i]),
      .hit_pulse  (hit_pulse[i]),
      .miss_pulse (miss_pulse[i])
    );
    assign lane_y[10*i +: 10] = lane_y_arr[i];
  end

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);

    // Hits land on the same edge as their strobes; the sum is wide enough
    // that the saturation test never sees a wrapped value.
    hit_cnt = '0;
    for (int i = 0; i < NLANES; i++) begin
      hit_cnt = hit_cnt + SUMW'(hit_evt[i]);
    end
    score_sum = SUMW'(score_q) + hit_cnt;
    score_d   = (score_sum > SUMW'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCOREW-1:0];
  end

  // Walk lanes from highest to lowest so the lowest matching index wins.
  always_comb begin
    ov_hit = 1'b0;
    ov_col = COL_GREEN;
    for (int i = NLANES - 1; i >= 0; i--) begin
      if ((int'(hCount) >= LANE_X0 + i * LANE_PITCH) &&
          (int'(hCount) <  LANE_X0 + i * LANE_PITCH + BLOCK_W) &&
          (int'(vCount) >= int'(lane_y_arr[i])) &&
          (int'(vCount) <= int'(lane_y_arr[i]) + BLOCK_H)) begin
        ov_hit = 1'b1;
        ov_col = (lane_st[i] == LANE_SCORED) ? COL_GREY : COL_GREEN;
      end
    end
  end

  always_comb begin
    pix_ext = {4'b0000, pix};
    if (!bright) begin
      rgb_d = COL_BLACK;
    end else if (ov_hit) begin
      rgb_d = ov_col;
    end else if (pix_ext <= (CIDXW + 4)'(PAL_GREY)) begin
      rgb_d = pal_colour(pix_ext[3:0]);
    end else begin
      rgb_d = COL_BG;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt_q <= '0;
      score_q    <= '0;
      rgb_q      <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      score_q    <= score_d;
      rgb_q      <= rgb_d;
    end
  end

  assign rgb   = rgb_q;
  assign score = score_q;

endmodule
